hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised hazard and bypass control unit for the in-order integer pipeline.
- Tracks in-flight register writebacks across a configurable number of post-decode stages.
- Produces the decode stall and per-source-operand bypass selects.
- Generalises the fixed exe/mem/wb stall logic to N stages and M source operands, with a configurable load-result latency and CSR serialisation.

Parameters:
- NUM_STAGES, 3, post-decode stages tracked (stage 0 = exe, NUM_STAGES-1 = wb); range 2..8
- NUM_SRC, 2, source operands checked per decoded instruction; range 1..4
- REG_AW, 5, register address width
- LOAD_READY_STAGE, 1, first stage index whose output carries load data; must be < NUM_STAGES
- SELW, $clog2(NUM_STAGES+1), bypass select width (derived, not overridable)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- dec_valid  in  1  decode holds a valid instruction
- dec_kill  in  1  decode instruction squashed by branch unit
- dec_rd  in  REG_AW  destination register of decode instruction
- dec_rf_wen  in  1  decode instruction writes register file
- dec_is_load  in  1  decode instruction is a load
- dec_is_csr  in  1  decode instruction is a CSR access
- dec_rs_addr  in  NUM_SRC*REG_AW  source addresses, operand i at [i*REG_AW +: REG_AW]
- dec_rs_oen  in  NUM_SRC  source operand enables
- cmiss_stall  in  1  memory-miss freeze of whole pipeline
- dec_stall  out  1  hold decode/fetch, inject bubble into stage 0
- byp_sel  out  NUM_SRC*SELW  per operand: 0 = register file, k+1 = forward from stage k
- stage_busy  out  NUM_STAGES  stage k holds an instruction with rf_wen=1 (debug/verification)

Behaviour:
- State: per stage k, entry {valid, rd, wen, is_load, is_csr}. All fields are registered.
- Reset: all entries cleared next edge. dec_stall=0, byp_sel=0, stage_busy=0 while empty. Reset wins over cmiss_stall and mid-stream contents.
- Advance, when cmiss_stall=0:
  - entry k+1 <= entry k; entry NUM_STAGES-1 retires.
  - Stage 0 <= decode fields if dec_valid & !dec_kill & !dec_stall, else bubble (all zero).
- Freeze: cmiss_stall=1 holds every entry unchanged. Outputs stay combinationally valid from the held state.
- Match for operand i at stage k: valid & wen & rd==rs_i & rs_i!=0 & dec_rs_oen[i]. Register x0 never matches.
- Youngest producer wins. Bypass source = lowest matching k.
- Ready: an entry at stage k has result available if !is_load or k >= LOAD_READY_STAGE.
- dec_stall = dec_valid & !dec_kill & (any operand's youngest match not ready, or any stage 0 entry with is_csr=1). Purely combinational from state plus decode inputs.
- byp_sel[i] = k+1 for youngest ready match, else 0. Forced 0 when operand not enabled.
- Simultaneous stall and kill: kill takes precedence, so dec_stall=0 and a bubble enters.
- The writeback stage (NUM_STAGES-1) match is forwarded, not written-first through the register file.

Optional Feature:
- Macro: HAZARD_BYPASS_EN.
- Defined: forwarding as above; stalls only on load-use and CSR.
- Undefined: full interlock.
  - byp_sel tied to 0.
  - dec_stall asserted on any match in any stage 0..NUM_STAGES-1, regardless of ready, plus CSR rule.
  - Ready/load tracking logic removed.

Test Plan (defaults, x5 = 5'd5):
- ADD rd=x5 decoded, next cycle rs1=x5 oen=1 [BYPASS_EN] -> dec_stall=0, byp_sel[0]=1; one cycle later (rs1=x5 still) byp_sel[0]=2.
- LW rd=x5, next cycle rs2=x5 [BYPASS_EN] -> dec_stall=1 for exactly 1 cycle; next cycle byp_sel[1]=2, stall=0.
- ADD rd=x5, then dependent rs1=x5, macro undefined -> dec_stall=1 for 3 cycles, byp_sel=0 throughout, issues on cycle 4.
- Producer rd=x0 rf_wen=1, consumer rs1=x0 -> dec_stall=0, byp_sel=0. Separately, CSRRW enters stage 0 -> dec_stall=1 for 1 cycle.
- LW rd=x5 in stage 0, cmiss_stall=1 for 4 cycles, consumer rs1=x5 -> stage_busy=3'b001 held, dec_stall=1 all 4 cycles; after release stall 1 more cycle, then byp_sel[0]=2.
- Pipeline full of wen entries, reset pulsed 1 cycle -> next cycle stage_busy=0, dec_stall=0, byp_sel=0. Same with dec_kill=1 on a hazarding consumer -> dec_stall=0, bubble enters.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Hazard/bypass control: tracks in-flight writebacks per post-decode stage, drives decode stall and operand bypass selects.
// HAZARD_BYPASS_EN defined: forwarding with load-use/CSR stalls; undefined: full interlock, byp_sel tied to 0.
module hazard_scoreboard #(
    parameter int unsigned NUM_STAGES       = 3,
    parameter int unsigned NUM_SRC          = 2,
    parameter int unsigned REG_AW           = 5,
    parameter int unsigned LOAD_READY_STAGE = 1,
    localparam int unsigned SELW            = $clog2(NUM_STAGES + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       dec_valid,
    input  logic                       dec_kill,
    input  logic [REG_AW-1:0]          dec_rd,
    input  logic                       dec_rf_wen,
    input  logic                       dec_is_load,
    input  logic                       dec_is_csr,
    input  logic [NUM_SRC*REG_AW-1:0]  dec_rs_addr,
    input  logic [NUM_SRC-1:0]         dec_rs_oen,
    input  logic                       cmiss_stall,
    output logic                       dec_stall,
    output logic [NUM_SRC*SELW-1:0]    byp_sel,
    output logic [NUM_STAGES-1:0]      stage_busy
);

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] rd;
        logic              wen;
`ifdef HAZARD_BYPASS_EN
        logic              is_load;
`endif
        logic              is_csr;
    } entry_t;

    entry_t stage_q [NUM_STAGES];
    entry_t stage_d [NUM_STAGES];

    logic [NUM_SRC-1:0] hit;
    logic               hazard;
    logic               issue;

`ifndef HAZARD_BYPASS_EN
    logic        unused_load;
    int unsigned unused_lrs;
    assign unused_load = dec_is_load;
    assign unused_lrs  = LOAD_READY_STAGE;
`endif

    function automatic logic src_match(entry_t e, logic [REG_AW-1:0] rs);
        return e.valid & e.wen & (e.rd == rs) & (rs != '0);
    endfunction

    // Ascending scan with hit[] as the found flag: the first (youngest) match sticks.
    always_comb begin
        hit     = '0;
        hazard  = 1'b0;
        byp_sel = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                if (dec_rs_oen[i] && !hit[i] &&
                    src_match(stage_q[k], dec_rs_addr[i*REG_AW +: REG_AW])) begin
                    hit[i] = 1'b1;
`ifdef HAZARD_BYPASS_EN
                    if (!stage_q[k].is_load || k >= LOAD_READY_STAGE)
                        byp_sel[i*SELW +: SELW] = SELW'(k + 1);
                    else
                        hazard = 1'b1;
`else
                    hazard = 1'b1;
`endif
                end
            end
        end
    end

    assign dec_stall = dec_valid & ~dec_kill & (hazard | (stage_q[0].valid & stage_q[0].is_csr));
    assign issue     = dec_valid & ~dec_kill & ~dec_stall;

    always_comb begin
        for (int unsigned k = 0; k < NUM_STAGES; k++)
            stage_busy[k] = stage_q[k].valid & stage_q[k].wen;
    end

    always_comb begin
        stage_d = stage_q;
        if (!cmiss_stall) begin
            stage_d[0] = '0;
            if (issue) begin
                stage_d[0].valid   = 1'b1;
                stage_d[0].rd      = dec_rd;
                stage_d[0].wen     = dec_rf_wen;
`ifdef HAZARD_BYPASS_EN
                stage_d[0].is_load = dec_is_load;
`endif
                stage_d[0].is_csr  = dec_is_csr;
            end
            for (int unsigned k = 1; k < NUM_STAGES; k++)
                stage_d[k] = stage_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned k = 0; k < NUM_STAGES; k++)
                stage_q[k] <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard at default parameters; expectations switch on HAZARD_BYPASS_EN.
module tb_hazard_scoreboard;

`ifdef HAZARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       dec_valid, dec_kill, dec_rf_wen, dec_is_load, dec_is_csr, cmiss_stall;
    logic [4:0] dec_rd;
    logic [9:0] dec_rs_addr;
    logic [1:0] dec_rs_oen;
    logic       dec_stall;
    logic [3:0] byp_sel;
    logic [2:0] stage_busy;

    hazard_scoreboard dut (
        .clk        (clk),
        .reset      (reset),
        .dec_valid  (dec_valid),
        .dec_kill   (dec_kill),
        .dec_rd     (dec_rd),
        .dec_rf_wen (dec_rf_wen),
        .dec_is_load(dec_is_load),
        .dec_is_csr (dec_is_csr),
        .dec_rs_addr(dec_rs_addr),
        .dec_rs_oen (dec_rs_oen),
        .cmiss_stall(cmiss_stall),
        .dec_stall  (dec_stall),
        .byp_sel    (byp_sel),
        .stage_busy (stage_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string    name;
        bit       rst, v, kill;
        bit [4:0] rd;
        bit       wen, ld, csr;
        bit [4:0] rs1, rs2;
        bit [1:0] oen;
        bit       cmiss;
        bit       e_stall;
        bit [3:0] e_sel;
        bit [2:0] e_busy;
    } vec_t;

    typedef struct {
        string    name;
        bit       stall;
        bit [3:0] sel;
        bit [2:0] busy;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    function automatic void add(string n, bit rst, bit v, bit kill, bit [4:0] rd, bit wen, bit ld,
                                bit csr, bit [4:0] rs1, bit [4:0] rs2, bit [1:0] oen, bit cmiss,
                                bit es, bit [3:0] esel, bit [2:0] eb);
        vecs.push_back('{n, rst, v, kill, rd, wen, ld, csr, rs1, rs2, oen, cmiss, es, esel, eb});
    endfunction

    function automatic void idle(string n, bit [2:0] eb);
        add(n, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 4'h0, eb);
    endfunction

    task automatic check(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(vec_t t);
        reset       = t.rst;
        dec_valid   = t.v;
        dec_kill    = t.kill;
        dec_rd      = t.rd;
        dec_rf_wen  = t.wen;
        dec_is_load = t.ld;
        dec_is_csr  = t.csr;
        dec_rs_addr = {t.rs2, t.rs1};
        dec_rs_oen  = t.oen;
        cmiss_stall = t.cmiss;
    endtask

    initial begin
        exp_t e;
        int   n;

        // ADD x5 then dependent rs1=x5 (forward 1,2,3 / interlock 3 cycles)
        add("A0", 0,1,0, 5,1,0,0, 0,0,2'b00,0, 0, 4'h0, 3'b000);
        add("A1", 0,1,0, 0,0,0,0, 5,0,2'b01,0, !BYP, BYP ? 4'h1 : 4'h0, 3'b001);
        add("A2", 0,1,0, 0,0,0,0, 5,0,2'b01,0, !BYP, BYP ? 4'h2 : 4'h0, 3'b010);
        add("A3", 0,1,0, 0,0,0,0, 5,0,2'b01,0, !BYP, BYP ? 4'h3 : 4'h0, 3'b100);
        add("A4", 0,1,0, 0,0,0,0, 5,0,2'b01,0, 0, 4'h0, 3'b000);
        // LW x5 then rs2=x5 (load-use)
        add("B0", 0,1,0, 5,1,1,0, 0,0,2'b00,0, 0, 4'h0, 3'b000);
        add("B1", 0,1,0, 0,0,0,0, 0,5,2'b10,0, 1, 4'h0, 3'b001);
        add("B2", 0,1,0, 0,0,0,0, 0,5,2'b10,0, !BYP, BYP ? 4'h8 : 4'h0, 3'b010);
        add("B3", 0,1,0, 0,0,0,0, 0,5,2'b10,0, !BYP, BYP ? 4'hC : 4'h0, 3'b100);
        add("B4", 0,1,0, 0,0,0,0, 0,5,2'b10,0, 0, 4'h0, 3'b000);
        // x0 never matches
        add("C0", 0,1,0, 0,1,0,0, 0,0,2'b00,0, 0, 4'h0, 3'b000);
        add("C1", 0,1,0, 0,0,0,0, 0,0,2'b01,0, 0, 4'h0, 3'b001);
        idle("C2", 3'b010); idle("C3", 3'b100); idle("C4", 3'b000);
        // CSR in stage 0 serialises
        add("D0", 0,1,0, 5,1,0,1, 0,0,2'b00,0, 0, 4'h0, 3'b000);
        add("D1", 0,1,0, 6,1,0,0, 7,0,2'b01,0, 1, 4'h0, 3'b001);
        add("D2", 0,1,0, 6,1,0,0, 7,0,2'b01,0, 0, 4'h0, 3'b010);
        idle("D3", 3'b101); idle("D4", 3'b010); idle("D5", 3'b100); idle("D6", 3'b000);
        // Memory-miss freeze with a load in stage 0
        add("E0", 0,1,0, 5,1,1,0, 0,0,2'b00,0, 0, 4'h0, 3'b000);
        for (int i = 1; i <= 4; i++)
            add($sformatf("E%0d", i), 0,1,0, 0,0,0,0, 5,0,2'b01,1, 1, 4'h0, 3'b001);
        add("E5", 0,1,0, 0,0,0,0, 5,0,2'b01,0, 1, 4'h0, 3'b001);
        add("E6", 0,1,0, 0,0,0,0, 5,0,2'b01,0, !BYP, BYP ? 4'h2 : 4'h0, 3'b010);
        add("E7", 0,1,0, 0,0,0,0, 5,0,2'b01,0, !BYP, BYP ? 4'h3 : 4'h0, 3'b100);
        add("E8", 0,1,0, 0,0,0,0, 5,0,2'b01,0, 0, 4'h0, 3'b000);
        // Full pipeline, reset wins over cmiss_stall
        add("F0", 0,1,0, 1,1,0,0, 0,0,2'b00,0, 0, 4'h0, 3'b000);
        add("F1", 0,1,0, 2,1,0,0, 0,0,2'b00,0, 0, 4'h0, 3'b001);
        add("F2", 0,1,0, 3,1,0,0, 0,0,2'b00,0, 0, 4'h0, 3'b011);
        add("F3", 1,1,0, 0,0,0,0, 3,0,2'b01,1, !BYP, BYP ? 4'h1 : 4'h0, 3'b111);
        add("F4", 0,1,0, 0,0,0,0, 3,0,2'b01,0, 0, 4'h0, 3'b000);
        idle("F5", 3'b000);
        // Kill beats stall; killed instruction leaves a bubble
        add("G0", 0,1,0, 5,1,1,0, 0,0,2'b00,0, 0, 4'h0, 3'b000);
        add("G1", 0,1,1, 9,1,0,0, 5,0,2'b01,0, 0, 4'h0, 3'b001);
        idle("G2", 3'b010); idle("G3", 3'b100); idle("G4", 3'b000);

        drive('{"rst", 1,0,0, 0,0,0,0, 0,0,2'b00,0, 0, 4'h0, 3'b000});
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            drive(vecs[i]);
            exp_q.push_back('{vecs[i].name, vecs[i].e_stall, vecs[i].e_sel, vecs[i].e_busy});
            @(negedge clk);
            e = exp_q.pop_front();
            check({e.name, ".stall"}, int'(dec_stall),  int'(e.stall));
            check({e.name, ".sel"},   int'(byp_sel),    int'(e.sel));
            check({e.name, ".busy"},  int'(stage_busy), int'(e.busy));
            @(posedge clk);
            #1;
        end

        // Load-use: wait for decode to release within a bounded budget
        drive('{"H0", 0,1,0, 5,1,1,0, 0,0,2'b00,0, 0, 4'h0, 3'b000});
        @(posedge clk);
        #1;
        drive('{"H1", 0,1,0, 0,0,0,0, 5,0,2'b01,0, 0, 4'h0, 3'b000});
        #1;
        n = 0;
        while (dec_stall && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("H.stall_cycles", n, BYP ? 1 : 3);
        check("H.sel_at_issue", int'(byp_sel), BYP ? 2 : 0);
        drive('{"H2", 0,0,0, 0,0,0,0, 0,0,2'b00,0, 0, 4'h0, 3'b000});
        repeat (4) @(posedge clk);
        #1;
        check("H.drained", int'(stage_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
